binary_div_12_6_uni: RTL and testbench

Sequential unsigned divider that inverts the 6×6 unsigned multiplier datapath. It takes a 12-bit dividend, such as a product `P`, and a 6-bit divisor, and returns a 12-bit quotient and 6-bit remainder. It uses restoring division, one quotient bit per clock. It sits beside the multiplier blocks in the unsigned arithmetic set, with a valid/ready handshake on both sides and the same `en` clock-enable convention.

---
 rtl/binary_div_pkg.sv | 8 +
 rtl/binary_div_12_6_uni_if.sv | 15 +
 rtl/binary_div_step.sv | 16 +
 rtl/binary_div_12_6_uni.sv | 77 +++++++
 tb/tb_binary_div_12_6_uni.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/binary_div_pkg.sv
// binary_div_pkg: widths, state encoding and constants for the 12/6 unsigned divider
package binary_div_pkg;
  localparam int DIVIDEND_W = 12;
  localparam int DIVISOR_W  = 6;
  localparam int CNT_W      = 4;
  localparam logic [DIVIDEND_W-1:0] DZ_QUOT = 12'hFFF;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/binary_div_12_6_uni_if.sv
// binary_div_12_6_uni_if: request/response handshake bundle for the divider
interface binary_div_12_6_uni_if;
  import binary_div_pkg::*;
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] P;
  logic [DIVISOR_W-1:0]  B;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] Q;
  logic [DIVISOR_W-1:0]  R;
  logic                  dz;
  modport master (output in_valid, P, B, out_ready, input in_ready, out_valid, Q, R, dz);
  modport slave  (input in_valid, P, B, out_ready, output in_ready, out_valid, Q, R, dz);
endinterface

// File: rtl/binary_div_step.sv
// binary_div_step: one combinational restoring-division step
module binary_div_step
  import binary_div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_n,
  output logic                 q
);
  logic [DIVISOR_W:0] rem7;
  assign rem7  = {rem, din};
  assign q     = rem7 >= {1'b0, divisor};
  // remainder stays below the divisor, so it always fits back into 6 bits
  assign rem_n = DIVISOR_W'(q ? rem7 - {1'b0, divisor} : rem7);
endmodule

// File: rtl/binary_div_12_6_uni.sv
// binary_div_12_6_uni: sequential restoring divider, one quotient bit per enabled clock
module binary_div_12_6_uni
  import binary_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  binary_div_12_6_uni_if.slave bus
);
  div_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W-1:0]  rem_n;
  logic [DIVIDEND_W-2:0] quot;
  logic                  qbit;
  assign bus.in_ready = (state == IDLE) & en & ~rst;
  binary_div_step u_step (
    .rem    (rem),
    .din    (dvd[DIVIDEND_W-1]),
    .divisor(dsr),
    .rem_n  (rem_n),
    .q      (qbit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      quot          <= '0;
      bus.Q         <= '0;
      bus.R         <= '0;
      bus.dz        <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (bus.in_valid) begin
          dvd  <= bus.P;
          dsr  <= bus.B;
          rem  <= '0;
          quot <= '0;
          cnt  <= CNT_W'(DIVIDEND_W - 1);
          if (bus.B == '0) begin
            state         <= DONE;
            bus.Q         <= DZ_QUOT;
            bus.R         <= '0;
            bus.dz        <= 1'b1;
            bus.out_valid <= 1'b1;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          dvd  <= {dvd[DIVIDEND_W-2:0], 1'b0};
          rem  <= rem_n;
          quot <= {quot[DIVIDEND_W-3:0], qbit};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            state         <= DONE;
            bus.Q         <= {quot, qbit};
            bus.R         <= rem_n;
            bus.dz        <= 1'b0;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_binary_div_12_6_uni.sv
// tb_binary_div_12_6_uni: directed and sweep checks of the 12/6 divider
module tb_binary_div_12_6_uni;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat;
  logic [11:0] q_hold;
  logic [5:0]  r_hold;
  logic [11:0] rp;
  logic [5:0]  rb;
  binary_div_12_6_uni_if bus ();
  binary_div_12_6_uni dut (.clk(clk), .rst(rst), .en(en), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat counts enabled-or-not edges after the accept edge until out_valid is seen
  task automatic op(input logic [11:0] p, input logic [5:0] b, input bit drop, output int l);
    int w = 0;
    while (!bus.in_ready && w < 50) begin tick(); w++; end
    chk("ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.P = p;
    bus.B = b;
    tick();
    bus.in_valid = 1'b0;
    bus.P = $urandom_range(4095);
    bus.B = $urandom_range(63);
    l = 0;
    while (!bus.out_valid && l < 40) begin
      en = !(drop && l >= 4 && l < 7);
      tick();
      l++;
    end
    en = 1'b1;
    if (!bus.out_valid) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [11:0] p, input logic [5:0] b,
                     input logic [11:0] eq, input logic [5:0] er, input logic edz, input int elat);
    op(p, b, 1'b0, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_Q"}, 32'(bus.Q), 32'(eq));
    chk({tag, "_R"}, 32'(bus.R), 32'(er));
    chk({tag, "_dz"}, 32'(bus.dz), 32'(edz));
    take();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.P = '0;
    bus.B = '0;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_Q", 32'(bus.Q), 32'd0);
    chk("rst_R", 32'(bus.R), 32'd0);
    chk("rst_dz", 32'(bus.dz), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    run("d100_7", 12'd100, 6'd7, 12'd14, 6'd2, 1'b0, 12);
    run("d4095_1", 12'd4095, 6'd1, 12'd4095, 6'd0, 1'b0, 12);
    run("d3969_63", 12'd3969, 6'd63, 12'd63, 6'd0, 1'b0, 12);
    run("d5_63", 12'd5, 6'd63, 12'd0, 6'd5, 1'b0, 12);
    run("dz37", 12'd37, 6'd0, 12'hFFF, 6'd0, 1'b1, 0);
    run("after_dz", 12'd100, 6'd7, 12'd14, 6'd2, 1'b0, 12);
    op(12'd1000, 6'd13, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_Q", 32'(bus.Q), 32'd76);
      chk("hold_R", 32'(bus.R), 32'd12);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    take();
    chk("post_take_out_valid", 32'(bus.out_valid), 32'd0);
    op(12'd2000, 6'd21, 1'b1, lat);
    chk("en_drop_lat", 32'(lat), 32'd15);
    chk("en_drop_Q", 32'(bus.Q), 32'd95);
    chk("en_drop_R", 32'(bus.R), 32'd5);
    take();
    bus.in_valid = 1'b1;
    bus.P = 12'd500;
    bus.B = 6'd3;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_Q", 32'(bus.Q), 32'd0);
    chk("midrst_R", 32'(bus.R), 32'd0);
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.out_valid) chk("midrst_no_output", 32'(bus.out_valid), 32'd0);
    end
    run("d63_9", 12'd63, 6'd9, 12'd7, 6'd0, 1'b0, 12);
    for (int i = 0; i < 64; i++) begin
      for (int j = 1; j < 64; j++) begin
        op(12'(i * j), 6'(j), 1'b0, lat);
        chk("sweep_Q", 32'(bus.Q), 32'(i));
        chk("sweep_R", 32'(bus.R), 32'd0);
        take();
      end
    end
    for (int k = 0; k < 60; k++) begin
      rp = 12'($urandom_range(4095));
      rb = 6'($urandom_range(63, 1));
      op(rp, rb, 1'b0, lat);
      chk("rand_recon", 32'(bus.Q) * 32'(rb) + 32'(bus.R), 32'(rp));
      chk("rand_rlt", 32'(bus.R < rb), 32'd1);
      q_hold = bus.Q;
      r_hold = bus.R;
      chk("rand_Q", 32'(q_hold), 32'(rp / 12'(rb)));
      chk("rand_R", 32'(r_hold), 32'(rp % 12'(rb)));
      take();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
